// File: rtl/vend_controller_if.sv
// Vending controller bus: the user-facing coin/select/cancel inputs, the
// product-selector handshake, and the credit/change/status outputs.
//   slave  : the controller side (samples user and selector inputs,
//            drives price request, dispense, credit, change, busy, error)
//   master : the environment side (user panel + product selector)
interface vend_controller_if;
    logic       coin_valid;
    logic [4:0] coin_value;
    logic       select_valid;
    logic [1:0] product_sel;
    logic       cancel;
    logic [4:0] product_price;
    logic       product_dispense_done;
    logic       signal_product_selector;
    logic [1:0] product_sel_out;
    logic       product_dispense_en;
    logic [4:0] credit;
    logic       change_valid;
    logic [4:0] change_amount;
    logic       busy;
    logic       error;

    modport slave (
        input  coin_valid, coin_value, select_valid, product_sel, cancel,
               product_price, product_dispense_done,
        output signal_product_selector, product_sel_out, product_dispense_en,
               credit, change_valid, change_amount, busy, error
    );

    modport master (
        output coin_valid, coin_value, select_valid, product_sel, cancel,
               product_price, product_dispense_done,
        input  signal_product_selector, product_sel_out, product_dispense_en,
               credit, change_valid, change_amount, busy, error
    );
endinterface

// File: rtl/vend_controller.sv
// Vending machine controller. Collects coins into a 5-bit credit, looks up
// the price of a selected product through the product selector, dispenses
// when credit covers the price and returns the remainder as change. Cancel
// or an idle timeout in COLLECT refunds the full credit.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - vend_controller_if.slave (user inputs, selector handshake,
//            credit / change / busy / error outputs)
// Parameter:
//   TIMEOUT_CYC - idle cycles in COLLECT before an automatic refund
module vend_controller #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic              clk,
    input  logic              rst_n,
    vend_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, COLLECT, PRICE_REQ, PRICE_WAIT, COMPARE, DISPENSE, CHANGE
    } state_t;

    state_t      state;
    logic [4:0]  credit;
    logic [4:0]  price_r;
    logic [15:0] idle_cnt;
    logic        sps;
    logic [1:0]  sel_out;
    logic        disp_en;
    logic        chg_vld;
    logic [4:0]  chg_amt;
    logic        busy;
    logic        error;

    // 6-bit sum so an overflowing coin is detected instead of wrapping.
    logic [5:0]  coin_sum;
    logic        coin_take;
    logic        sel_take;
    logic        timeout_hit;
    logic        go_refund;
    logic [4:0]  remain;

    assign coin_sum    = {1'b0, credit} + {1'b0, bus.coin_value};
    assign coin_take   = bus.coin_valid && !coin_sum[5];
    // Any coin (accepted or rejected) outranks a select on the same cycle.
    assign sel_take    = bus.select_valid && !bus.coin_valid;
    assign timeout_hit = (idle_cnt == TIMEOUT_CYC - 16'd1);
    assign go_refund   = bus.cancel || (!coin_take && !sel_take && timeout_hit);
    assign remain      = credit - price_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit   <= '0;
            price_r  <= '0;
            idle_cnt <= '0;
            sps      <= 1'b0;
            sel_out  <= '0;
            disp_en  <= 1'b0;
            chg_vld  <= 1'b0;
            chg_amt  <= '0;
            busy     <= 1'b0;
            error    <= 1'b0;
        end else begin
            error   <= 1'b0;
            chg_vld <= 1'b0;
            // busy mirrors the current state, so a coin seen while busy
            // is one arriving outside IDLE/COLLECT.
            if (bus.coin_valid && busy)
                error <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.coin_valid) begin
                        credit   <= bus.coin_value;
                        idle_cnt <= '0;
                        state    <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (!bus.cancel && bus.coin_valid && coin_sum[5])
                        error <= 1'b1;
                    if (go_refund) begin
                        // Change strobe is launched on entry so it is
                        // visible during the CHANGE cycle itself.
                        chg_vld <= (credit != 5'd0);
                        if (credit != 5'd0)
                            chg_amt <= credit;
                        busy  <= 1'b1;
                        state <= CHANGE;
                    end else if (coin_take) begin
                        credit   <= coin_sum[4:0];
                        idle_cnt <= '0;
                    end else if (sel_take) begin
                        sel_out  <= bus.product_sel;
                        sps      <= 1'b1;
                        busy     <= 1'b1;
                        idle_cnt <= '0;
                        state    <= PRICE_REQ;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end

                PRICE_REQ: begin
                    sps   <= 1'b0;
                    state <= PRICE_WAIT;
                end

                PRICE_WAIT: begin
                    price_r <= bus.product_price;
                    state   <= COMPARE;
                end

                COMPARE: begin
                    // Price 0 marks an invalid selection.
                    if (price_r == 5'd0 || price_r > credit) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        idle_cnt <= '0;
                        state    <= COLLECT;
                    end else begin
                        disp_en <= 1'b1;
                        state   <= DISPENSE;
                    end
                end

                DISPENSE: begin
                    if (bus.product_dispense_done) begin
                        disp_en <= 1'b0;
                        credit  <= remain;
                        chg_vld <= (remain != 5'd0);
                        if (remain != 5'd0)
                            chg_amt <= remain;
                        state   <= CHANGE;
                    end
                end

                CHANGE: begin
                    credit <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.signal_product_selector = sps;
    assign bus.product_sel_out         = sel_out;
    assign bus.product_dispense_en     = disp_en;
    assign bus.credit                  = credit;
    assign bus.change_valid            = chg_vld;
    assign bus.change_amount           = chg_amt;
    assign bus.busy                    = busy;
    assign bus.error                   = error;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller. A small registered price table
// (15/20/25/0) stands in for the product selector. Expected change amounts
// are queued when a refund/purchase is driven and popped by a monitor when
// change_valid is seen; error pulses are counted and compared.
module tb_vend_controller;

    localparam logic [15:0] TMO = 16'd20;

    logic clk;
    logic rst_n;
    vend_controller_if bus();

    vend_controller #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int err_seen = 0;
    int exp_err = 0;
    int sb[$];

    // Product selector model: registered price lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.product_price <= 5'd0;
        else if (bus.signal_product_selector)
            case (bus.product_sel_out)
                2'd0:    bus.product_price <= 5'd15;
                2'd1:    bus.product_price <= 5'd20;
                2'd2:    bus.product_price <= 5'd25;
                default: bus.product_price <= 5'd0;
            endcase
    end

    // Change / error monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.error)
                err_seen++;
            if (bus.change_valid) begin
                int qn;
                qn = sb.size();
                n_vec++;
                assert (qn !== 0) else begin
                    n_mis++;
                    $error("FAIL change_spurious: observed amount %0d, required no strobe",
                           bus.change_amount);
                end
                if (qn != 0) begin
                    int e;
                    e = sb.pop_front();
                    assert (int'(bus.change_amount) === e) else begin
                        n_mis++;
                        $error("FAIL change_amount: observed %0d required %0d",
                               bus.change_amount, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [4:0] v);
        bus.coin_valid = 1'b1;
        bus.coin_value = v;
        tick();
        bus.coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] s);
        bus.select_valid = 1'b1;
        bus.product_sel  = s;
        tick();
        bus.select_valid = 1'b0;
    endtask

    // Select, run the full price/dispense handshake, check the change cycle.
    task automatic buy(input logic [1:0] s, input int chg);
        int n;
        if (chg != 0)
            sb.push_back(chg);
        select(s);
        chk("sps_high", bus.signal_product_selector, 1);
        chk("sel_out", bus.product_sel_out, s);
        chk("busy_req", bus.busy, 1);
        tick();
        chk("sps_one_cycle", bus.signal_product_selector, 0);
        n = 0;
        while (!bus.product_dispense_en && n < 8) begin
            tick();
            n++;
        end
        chk("dispense_en_latency", n, 2);
        repeat (3) tick();
        chk("dispense_en_held", bus.product_dispense_en, 1);
        bus.product_dispense_done = 1'b1;
        tick();
        bus.product_dispense_done = 1'b0;
        chk("dispense_en_drop", bus.product_dispense_en, 0);
        chk("credit_after_dispense", bus.credit, chg);
        chk("busy_change", bus.busy, 1);
        tick();
        chk("busy_idle", bus.busy, 0);
        chk("credit_idle", bus.credit, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_value = '0;
        bus.select_valid = 1'b0;
        bus.product_sel = '0;
        bus.cancel = 1'b0;
        bus.product_dispense_done = 1'b0;
        #22;
        chk("rst_credit", bus.credit, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dispense_en", bus.product_dispense_en, 0);
        chk("rst_change_valid", bus.change_valid, 0);
        chk("rst_error", bus.error, 0);
        rst_n = 1'b1;

        // Exact-credit purchase, no change.
        coin(5'd10);
        chk("credit_first_coin", bus.credit, 10);
        coin(5'd10);
        chk("credit_sum", bus.credit, 20);
        buy(2'd1, 0);

        // Purchase with change.
        coin(5'd10); coin(5'd10); coin(5'd5);
        chk("credit_25", bus.credit, 25);
        buy(2'd0, 10);

        // Insufficient credit, then cancel.
        coin(5'd10);
        select(2'd2);
        repeat (3) tick();
        chk("insuff_error", bus.error, 1);
        exp_err++;
        chk("insuff_busy", bus.busy, 0);
        chk("insuff_credit", bus.credit, 10);
        tick();
        chk("error_one_cycle", bus.error, 0);
        sb.push_back(10);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel_busy", bus.busy, 1);
        tick();
        chk("cancel_credit_clr", bus.credit, 0);
        chk("err_count_a", err_seen, exp_err);

        // Coin outranks select; overflow reject; cancel outranks coin.
        coin(5'd10);
        bus.select_valid = 1'b1;
        bus.product_sel  = 2'd0;
        coin(5'd10);
        bus.select_valid = 1'b0;
        chk("coin_over_select_credit", bus.credit, 20);
        chk("coin_over_select_sps", bus.signal_product_selector, 0);
        coin(5'd5);
        coin(5'd10);
        chk("overflow_error", bus.error, 1);
        exp_err++;
        chk("overflow_credit", bus.credit, 25);
        sb.push_back(25);
        bus.cancel = 1'b1;
        coin(5'd3);
        bus.cancel = 1'b0;
        chk("cancel_coin_busy", bus.busy, 1);
        chk("cancel_coin_no_err", bus.error, 0);
        tick();
        chk("cancel_coin_credit", bus.credit, 0);
        chk("err_count_b", err_seen, exp_err);

        // Idle timeout refund.
        coin(5'd5);
        repeat (int'(TMO) - 1) tick();
        chk("pre_timeout_busy", bus.busy, 0);
        chk("pre_timeout_credit", bus.credit, 5);
        sb.push_back(5);
        tick();
        chk("timeout_busy", bus.busy, 1);
        tick();
        chk("timeout_idle_credit", bus.credit, 0);
        chk("timeout_idle_busy", bus.busy, 0);

        // Invalid product, coin while busy, reset during DISPENSE.
        coin(5'd5);
        select(2'd3);
        repeat (3) tick();
        chk("invalid_error", bus.error, 1);
        exp_err++;
        chk("invalid_credit", bus.credit, 5);
        coin(5'd20);
        chk("credit_after_invalid", bus.credit, 25);
        select(2'd0);
        repeat (3) tick();
        chk("dispense_en_on", bus.product_dispense_en, 1);
        coin(5'd1);
        chk("busy_coin_error", bus.error, 1);
        exp_err++;
        chk("busy_coin_credit", bus.credit, 25);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_dispense_en", bus.product_dispense_en, 0);
        chk("rst_mid_credit", bus.credit, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_error", bus.error, 0);
        chk("rst_mid_sel_out", bus.product_sel_out, 0);
        chk("rst_mid_change_valid", bus.change_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        coin(5'd7);
        chk("post_rst_idle_credit", bus.credit, 7);
        sb.push_back(7);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        tick();
        chk("post_rst_refund_clr", bus.credit, 0);
        tick();

        chk("scoreboard_drained", sb.size(), 0);
        chk("err_count_final", err_seen, exp_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16'd1000, the number of idle cycles in COLLECT before an automatic refund.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port coin_valid, input, 1 bit, a one-cycle coin-inserted strobe.
REQ-005 The block SHALL have port coin_value, input, 5 bits, the coin credit units, sampled only when coin_valid=1.
REQ-006 The block SHALL have port select_valid, input, 1 bit, a one-cycle product-request strobe.
REQ-007 The block SHALL have port product_sel, input, 2 bits, the requested product, sampled only when select_valid=1.
REQ-008 The block SHALL have port cancel, input, 1 bit, the user refund request.
REQ-009 The block SHALL have port product_price, input, 5 bits, the registered price from the product selector.
REQ-010 The block SHALL have port product_dispense_done, input, 1 bit, the dispense acknowledge from the product selector.
REQ-011 The block SHALL have port signal_product_selector, output, 1 bit, the price-lookup request to the product selector.
REQ-012 The block SHALL have port product_sel_out, output, 2 bits, the latched selection driven to the product selector.
REQ-013 The block SHALL have port product_dispense_en, output, 1 bit, the dispense request.
REQ-014 The block SHALL have port credit, output, 5 bits, the current accumulated credit.
REQ-015 The block SHALL have port change_valid, output, 1 bit, a one-cycle strobe qualifying change_amount.
REQ-016 The block SHALL have port change_amount, output, 5 bits, the refund/change value.
REQ-017 The block SHALL have port busy, output, 1 bit, which is 1 in every state except IDLE and COLLECT.
REQ-018 The block SHALL have port error, output, 1 bit, a one-cycle strobe for any rejected event.

Function
REQ-019 The FSM SHALL have states IDLE, COLLECT, PRICE_REQ, PRICE_WAIT, COMPARE, DISPENSE and CHANGE, all registered.
REQ-020 In IDLE, an accepted coin SHALL set credit=coin_value and go to COLLECT; select_valid and cancel in IDLE SHALL be ignored.
REQ-021 In COLLECT, inputs SHALL be prioritised cancel > coin_valid > select_valid; a lower-priority event on the same cycle SHALL be dropped without error.
REQ-022 A coin SHALL be accepted only if the 6-bit sum credit+coin_value is <=31; otherwise credit is unchanged and error pulses for one cycle.
REQ-023 A coin arriving in any state other than IDLE or COLLECT SHALL be rejected with a one-cycle error pulse.
REQ-024 On select_valid in COLLECT, product_sel SHALL be latched into product_sel_out and the FSM SHALL go to PRICE_REQ.
REQ-025 In PRICE_REQ, signal_product_selector SHALL be 1 for exactly one cycle, then the FSM SHALL go to PRICE_WAIT.
REQ-026 In PRICE_WAIT, product_price SHALL be captured into an internal price register, and the FSM SHALL go to COMPARE.
REQ-027 In COMPARE, price=0 (invalid selection) SHALL pulse error and return to COLLECT.
REQ-028 In COMPARE, price>credit SHALL pulse error and return to COLLECT with credit unchanged.
REQ-029 In COMPARE, any other price SHALL go to DISPENSE.
REQ-030 In DISPENSE, product_dispense_en SHALL be held at 1 until product_dispense_done is sampled 1.
REQ-031 On the cycle product_dispense_done is sampled 1, product_dispense_en SHALL drop, credit SHALL be set to credit-price, and the FSM SHALL go to CHANGE.
REQ-032 In CHANGE, if credit is nonzero, change_valid SHALL be 1 for one cycle with change_amount=credit; if credit is zero, no strobe SHALL be issued.
REQ-033 In CHANGE, credit SHALL then clear to 0 and the FSM SHALL go to IDLE, one cycle total.
REQ-034 A cancel in COLLECT SHALL go to CHANGE, refunding the full credit.
REQ-035 cancel SHALL be ignored in PRICE_REQ through CHANGE.
REQ-036 A 16-bit idle counter SHALL run in COLLECT only and SHALL clear on entry to COLLECT and on any accepted coin or select.
REQ-037 When the idle counter reaches TIMEOUT_CYC-1, the FSM SHALL go to CHANGE, refunding the full credit.
REQ-038 change_amount SHALL hold its last value between strobes; change_amount is meaningful only while change_valid=1.

Reset
REQ-039 While rst_n=0, the FSM SHALL asynchronously enter IDLE and all outputs, credit, the price register and the idle counter SHALL be 0.
REQ-040 A reset mid-operation, including in DISPENSE, SHALL discard credit with no refund strobe, and product_dispense_en SHALL drop immediately.

Verification
REQ-041 With prices 15/20/25: coins 10,10 then select 01 -> one-cycle signal_product_selector, dispense_en held until done, no change_valid, credit=0, IDLE.
REQ-042 Coins 10,10,5 then select 00 -> dispense, then change_valid=1 with change_amount=10 for one cycle, credit=0.
REQ-043 Coin 10 then select 10 -> error pulse, FSM returns to COLLECT, credit=10; a subsequent cancel -> change_amount=10.
REQ-044 Credit 25, coin 10 -> error pulse, credit stays 25; a simultaneous cancel+coin -> refund 25, coin dropped.
REQ-045 Coin 5 followed by TIMEOUT_CYC idle cycles -> change_valid with change_amount=5, then IDLE.
REQ-046 Select 11 -> price 0, error pulse, FSM returns to COLLECT; rst_n low during DISPENSE -> all outputs 0 immediately, FSM in IDLE.
